// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial and/or/add/slt engine, one ALU slice stepped LSB first over WIDTH bits.
// Optional feature macro: ALU_SERIAL_ZERO_FLAG_EN (adds zero detect on the final result).
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic             i_binvert,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_ready,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_overflow,
  output logic             o_cout,
  output logic             o_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_ADD = 2'd2;
  localparam logic [1:0] OP_SLT = 2'd3;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_result;
  logic [WIDTH-2:0] r_sh;
  logic [1:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_binv, r_carry, r_set, r_overflow, r_cout;
  logic             w_accept, w_last, w_finish, w_b2, w_sum, w_carry, w_bit, w_ovf, w_set;
  logic [WIDTH-1:0] w_cat, w_final;

  // One ALU slice on the current LSBs plus commit/result assembly
  always_comb begin
    w_accept = (r_state == S_IDLE) && i_start;
    w_last   = (r_state == S_RUN) && (r_cnt == LAST);
    w_b2     = r_b[0] ^ r_binv;
    w_sum    = r_a[0] ^ w_b2 ^ r_carry;
    w_carry  = (r_a[0] & w_b2) | (r_a[0] & r_carry) | (w_b2 & r_carry);
    w_bit    = (r_op == OP_AND) ? (r_a[0] & r_b[0]) :
               (r_op == OP_OR)  ? (r_a[0] | r_b[0]) :
               (r_op == OP_ADD) ? w_sum : 1'b0;
    w_ovf    = (r_a[0] == w_b2) && (w_sum != r_a[0]);
    w_set    = (r_a[0] != w_b2) ? w_sum : r_a[0];
    w_cat    = {w_bit, r_sh};
    w_finish = (w_last && (r_op != OP_SLT)) || (r_state == S_FIX);
    w_final  = (r_state == S_FIX) ? {{(WIDTH-1){1'b0}}, r_set} : w_cat;
  end

  // Next-state decode: slt takes the extra FIX cycle before DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = i_start ? S_RUN : S_IDLE;
      S_RUN:   w_next = !w_last ? S_RUN : (r_op == OP_SLT) ? S_FIX : S_DONE;
      S_FIX:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Operand shifters, carry chain, bit counter and slt set capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sh    <= '0;
      r_op    <= OP_AND;
      r_binv  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_set   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_sh    <= '0;
      r_op    <= i_op;
      r_binv  <= i_binvert | (i_op == OP_SLT);
      r_carry <= i_binvert | (i_op == OP_SLT);
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sh    <= w_cat[WIDTH-1:1];
      r_carry <= w_carry;
      r_cnt   <= w_last ? r_cnt : r_cnt + CW'(1);
      if (w_last) r_set <= w_set;
    end
  end

  // Visible result and flags change only when an operation completes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_cout     <= 1'b0;
    end else if (w_finish) begin
      r_result   <= w_final;
      r_overflow <= (r_op == OP_ADD) && w_ovf;
      r_cout     <= (r_op == OP_ADD) && w_carry;
    end
  end

`ifdef ALU_SERIAL_ZERO_FLAG_EN
  logic r_zero;

  // Zero flag tracks the committed result
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_zero <= 1'b0;
    else if (w_finish) r_zero <= ~|w_final;
  end

  assign o_zero = r_zero;
`else
  assign o_zero = 1'b0;
`endif

  assign o_ready    = (r_state == S_IDLE);
  assign o_done     = (r_state == S_DONE);
  assign o_result   = r_result;
  assign o_overflow = r_overflow;
  assign o_cout     = r_cout;
endmodule
